// File: rtl/nonrestoring_div.sv
// nonrestoring_div: multi-cycle signed non-restoring divider, one quotient bit per cycle
module nonrestoring_div #(
    parameter int Data_Width    = 8,
    parameter int Counter_Width = $clog2(Data_Width + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Start,
    input  logic signed [Data_Width-1:0] Dividend,
    input  logic signed [Data_Width-1:0] Divisor,
    output logic                         Busy,
    output logic                         Div_Finsh,
    output logic                         Div_By_Zero,
    output logic signed [Data_Width-1:0] Quotient,
    output logic signed [Data_Width-1:0] Remainder
);
    localparam int N = Data_Width;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t                   r_state, w_next;
    logic [Counter_Width-1:0] r_cnt;
    logic [N:0]               r_rem;
    logic [N-1:0]             r_quo, r_dvs;
    logic                     r_sq, r_sn, r_dz;
    logic                     w_accept, w_dz_in;
    logic [N-1:0]             w_abs_dd, w_abs_dv, w_q_fix, w_mag, w_r_fix;
    logic [N:0]               w_shift, w_rem_nx, w_rem_fix;
    assign w_accept  = Start && (r_state == IDLE || r_state == DONE);
    assign w_dz_in   = Divisor == '0;
    // magnitudes are unsigned so that -2^(N-1) maps to 2^(N-1) without loss
    assign w_abs_dd  = Dividend[N-1] ? N'(-Dividend) : N'(Dividend);
    assign w_abs_dv  = Divisor[N-1] ? N'(-Divisor) : N'(Divisor);
    assign w_shift   = {r_rem[N-1:0], r_quo[N-1]};
    assign w_rem_nx  = r_rem[N] ? w_shift + {1'b0, r_dvs} : w_shift - {1'b0, r_dvs};
    assign w_rem_fix = r_rem[N] ? r_rem + {1'b0, r_dvs} : r_rem;
    assign w_q_fix   = r_dz ? '1 : (r_sq ? -r_quo : r_quo);
    // on divide-by-zero the untouched dividend magnitude is still in r_quo
    assign w_mag     = r_dz ? r_quo : w_rem_fix[N-1:0];
    assign w_r_fix   = r_sn ? -w_mag : w_mag;
    assign Busy      = r_state == RUN || r_state == FIX;
    assign Div_Finsh = r_state == DONE;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next state: accept from IDLE/DONE, iterate, sign-fix, report
    always_comb begin
        w_next = IDLE;
        w_next = w_accept          ? (w_dz_in ? FIX : RUN) :
                 r_state == RUN    ? (r_cnt == Counter_Width'(1) ? FIX : RUN) :
                 r_state == FIX    ? DONE : IDLE;
    end
    // datapath: operand capture, one non-restoring step per RUN cycle, result registers in FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_sq        <= 1'b0;
            r_sn        <= 1'b0;
            r_dz        <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            Div_By_Zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= Counter_Width'(N);
            r_rem <= '0;
            r_quo <= w_abs_dd;
            r_dvs <= w_abs_dv;
            r_sq  <= Dividend[N-1] ^ Divisor[N-1];
            r_sn  <= Dividend[N-1];
            r_dz  <= w_dz_in;
        end else if (r_state == RUN) begin
            r_rem <= w_rem_nx;
            r_quo <= {r_quo[N-2:0], ~w_rem_nx[N]};
            r_cnt <= r_cnt - Counter_Width'(1);
        end else if (r_state == FIX) begin
            Quotient    <= w_q_fix;
            Remainder   <= w_r_fix;
            Div_By_Zero <= r_dz;
        end
    end
endmodule

// File: tb/tb_nonrestoring_div.sv
// tb_nonrestoring_div: vector table, corner sequences and random checks against an arithmetic model
module tb_nonrestoring_div;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              Start = 1'b0;
    logic signed [7:0] Dividend = '0, Divisor = '0;
    logic              Busy, Div_Finsh, Div_By_Zero;
    logic signed [7:0] Quotient, Remainder;
    int n_cmp = 0, n_err = 0;

    nonrestoring_div #(.Data_Width(8)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
        .Busy(Busy), .Div_Finsh(Div_Finsh), .Div_By_Zero(Div_By_Zero),
        .Quotient(Quotient), .Remainder(Remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] a, b, q, r;
        logic              dz;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // truncating division from plain integer arithmetic
    task automatic model(input logic signed [7:0] a, b, output logic signed [7:0] q, r, output logic dz);
        int ia, ib;
        ia = a;
        ib = b;
        dz = ib == 0;
        q  = dz ? 8'hFF : 8'(ia / ib);
        r  = dz ? a : 8'(ia % ib);
    endtask

    task automatic run_op(input logic signed [7:0] a, b, output logic signed [7:0] q, r,
                          output logic dz, output int lat, output int busy);
        @(negedge clk);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        lat  = 0;
        busy = Busy ? 1 : 0;
        while (!Div_Finsh && lat < 40) begin
            @(posedge clk);
            #1 lat++;
            if (Busy) busy++;
        end
        q  = Quotient;
        r  = Remainder;
        dz = Div_By_Zero;
    endtask

    task automatic check_op(input string tag, input logic signed [7:0] a, b);
        logic signed [7:0] q, r, eq, er;
        logic dz, edz;
        int lat, busy;
        model(a, b, eq, er, edz);
        run_op(a, b, q, r, dz, lat, busy);
        chk({tag, " quotient"}, q, eq);
        chk({tag, " remainder"}, r, er);
        chk({tag, " div_by_zero"}, dz, edz);
        chk({tag, " latency"}, lat, edz ? 1 : 9);
        chk({tag, " busy cycles"}, busy, edz ? 1 : 9);
    endtask

    initial begin
        vec_t vt[13];
        logic signed [7:0] q, r, a, b;
        logic dz;
        int lat, busy, pulses, fin_seen;
        vt = '{
            '{8'sd100,  8'sd7,    8'sd14,   8'sd2,   1'b0},
            '{-8'sd100, 8'sd7,    -8'sd14,  -8'sd2,  1'b0},
            '{8'sd100,  -8'sd7,   -8'sd14,  8'sd2,   1'b0},
            '{-8'sd100, -8'sd7,   8'sd14,   -8'sd2,  1'b0},
            '{8'sd7,    8'sd0,    -8'sd1,   8'sd7,   1'b1},
            '{8'sd7,    8'sd1,    8'sd7,    8'sd0,   1'b0},
            '{-8'sd128, -8'sd1,   -8'sd128, 8'sd0,   1'b0},
            '{-8'sd128, 8'sd1,    -8'sd128, 8'sd0,   1'b0},
            '{-8'sd128, 8'sd0,    -8'sd1,   -8'sd128, 1'b1},
            '{8'sd127,  -8'sd128, 8'sd0,    8'sd127, 1'b0},
            '{-8'sd128, -8'sd128, 8'sd1,    8'sd0,   1'b0},
            '{8'sd0,    8'sd5,    8'sd0,    8'sd0,   1'b0},
            '{8'sd3,    8'sd5,    8'sd0,    8'sd3,   1'b0}
        };
        #2;
        chk("reset busy", Busy, 0);
        chk("reset finish", Div_Finsh, 0);
        chk("reset quotient", Quotient, 0);
        chk("reset remainder", Remainder, 0);
        chk("reset div_by_zero", Div_By_Zero, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].a, vt[i].b, q, r, dz, lat, busy);
            chk($sformatf("vec%0d quotient", i), q, vt[i].q);
            chk($sformatf("vec%0d remainder", i), r, vt[i].r);
            chk($sformatf("vec%0d div_by_zero", i), dz, vt[i].dz);
            chk($sformatf("vec%0d latency", i), lat, vt[i].dz ? 1 : 9);
            chk($sformatf("vec%0d busy cycles", i), busy, vt[i].dz ? 1 : 9);
        end

        // Start pulsed mid-RUN must not disturb 50/3
        @(negedge clk);
        Dividend = 8'sd50; Divisor = 8'sd3; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (2) @(negedge clk);
        Dividend = 8'sd9; Divisor = 8'sd9; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        lat = 0;
        while (!Div_Finsh && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("ignore-start latency", lat, 6);
        chk("ignore-start quotient", Quotient, 16);
        chk("ignore-start remainder", Remainder, 2);
        @(posedge clk);
        #1 chk("ignore-start idle after done", Busy, 0);

        // Start held high: one result every 10 edges
        @(negedge clk);
        Dividend = 8'sd77; Divisor = -8'sd5; Start = 1'b1;
        @(posedge clk);
        pulses = 0;
        for (int e = 1; e <= 39; e++) begin
            @(posedge clk);
            #1;
            if (Div_Finsh) begin
                pulses++;
                chk($sformatf("b2b pulse at edge %0d", e), e % 10, 9);
                chk("b2b quotient", Quotient, -15);
                chk("b2b remainder", Remainder, 2);
            end
            if (e == 39) Start = 1'b0;
        end
        chk("b2b pulse count", pulses, 4);
        @(posedge clk);
        #1 chk("b2b idle after release", Busy, 0);

        // asynchronous reset in the middle of a division
        check_op("pre-reset", 8'sd7, 8'sd0);
        @(negedge clk);
        Dividend = 8'sd100; Divisor = 8'sd7; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset busy", Busy, 0);
        chk("midreset quotient", Quotient, 0);
        chk("midreset remainder", Remainder, 0);
        chk("midreset div_by_zero", Div_By_Zero, 0);
        @(negedge clk);
        rst = 1'b0;
        fin_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (Div_Finsh || Busy) fin_seen++;
        end
        chk("midreset no activity", fin_seen, 0);
        check_op("post-reset 20/4", 8'sd20, 8'sd4);

        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 8'sd0 : 8'($urandom);
            check_op($sformatf("rand %0d/%0d", a, b), a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
